// File: rtl/pattern_scheduler.sv
// Run/pause/mode controller for the LED pattern datapath: debounces the mode
// button, latches the mode switches and issues single-clock step/load enables.
module pattern_scheduler #(
  parameter int unsigned TICK_DIV = 5_000_000,  // cycles per step while running, >= 2
  parameter int unsigned DEBOUNCE = 200_000     // stable cycles to accept a level, >= 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic [1:0] sw,
  output logic [3:0] mode,
  output logic       step,
  output logic       load,
  output logic [1:0] state
);

  localparam int unsigned DC_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE - 1);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  logic            key_s1, key_s2;
  logic            db;
  logic [DC_W-1:0] dc;
  logic            db_accept;
  logic            press;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            presc_wrap;

  // Two-flop synchronizer; released level is 1 so reset looks like "not pressed".
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the synchronizer really is two stages deep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  assign db_accept = (key_s2 != db) && (dc == DC_MAX);

  // press fires on the same edge db falls, so it is high the cycle after.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db    <= 1'b1;
      dc    <= '0;
      press <= 1'b0;
    end else begin
      press <= db_accept && db;
      if (key_s2 == db) begin
        dc <= '0;
      end else if (dc == DC_MAX) begin
        db <= key_s2;
        dc <= '0;
      end else begin
        dc <= dc + 1'b1;
      end
    end
  end

  assign presc_wrap = (presc_q == PS_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
    end
  end

  // The prescaler counts every RUN cycle, including the one carrying a press,
  // and is frozen everywhere else; LOAD alone restarts it.
  // NOTE: every signal driven here gets a hold default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          mode_d  = sw;
          state_d = LOAD;
        end
      end
      LOAD: begin
        presc_d = '0;
        state_d = RUN;
      end
      RUN: begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        if (press) state_d = PAUSE;
      end
      PAUSE: begin
        if (press) begin
          if (sw != mode_q) begin
            mode_d  = sw;
            state_d = LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pure decodes of registered state, so both strobes are glitch-free.
  assign step  = (state_q == RUN) && presc_wrap;
  assign load  = (state_q == LOAD);
  assign mode  = {2'b00, mode_q};
  assign state = state_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler with TICK_DIV=5, DEBOUNCE=4: a
// per-cycle vector table plus hand-written reset and post-reset sequences.
module tb_pattern_scheduler;

  localparam int unsigned TICK_DIV = 5;
  localparam int unsigned DEBOUNCE = 4;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_n = 1'b1;
  logic [1:0] sw    = 2'b00;
  logic [3:0] mode;
  logic       step;
  logic       load;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic       key_n;
    logic [1:0] sw;
    logic [1:0] st;
    logic [3:0] md;
    logic       stp;
    logic       ld;
  } row_t;

  row_t vec[$];

  pattern_scheduler #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .sw   (sw),
    .mode (mode),
    .step (step),
    .load (load),
    .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Append n identical cycles: inputs before the edge, outputs expected after it.
  task automatic rows(input int n, input logic k, input logic [1:0] s, input logic [1:0] st,
                      input logic [3:0] md, input logic stp, input logic ld);
    row_t r;
    r = '{key_n: k, sw: s, st: st, md: md, stp: stp, ld: ld};
    for (int i = 0; i < n; i++) vec.push_back(r);
  endtask

  initial begin
    // Idle after reset.
    rows(20, 1, 2'd0, S_IDLE, 4'h0, 0, 0);
    // Press with sw=2: press accepted at edge 6, LOAD after edge 7, RUN after 8.
    rows(6, 0, 2'd2, S_IDLE, 4'h0, 0, 0);
    rows(1, 0, 2'd2, S_LOAD, 4'h2, 0, 1);
    rows(3, 0, 2'd2, S_RUN,  4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN,  4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN,  4'h2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      rows(4, 1, 2'd2, S_RUN, 4'h2, 0, 0);
      rows(1, 1, 2'd2, S_RUN, 4'h2, 1, 0);
    end
    // 3-cycle glitch in RUN: no event, cadence unchanged.
    rows(3, 0, 2'd2, S_RUN, 4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN, 4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN, 4'h2, 1, 0);
    rows(4, 1, 2'd2, S_RUN, 4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN, 4'h2, 1, 0);
    // Press lands on a step cycle: step still emitted, PAUSE holds count 0.
    rows(4, 1, 2'd2, S_RUN, 4'h2, 0, 0);
    rows(1, 0, 2'd2, S_RUN, 4'h2, 1, 0);
    rows(4, 0, 2'd2, S_RUN, 4'h2, 0, 0);
    rows(1, 0, 2'd2, S_RUN, 4'h2, 1, 0);
    rows(30, 1, 2'd2, S_PAUSE, 4'h2, 0, 0);
    // Resume, same sw, held 0: full period to next step, no load.
    rows(6, 0, 2'd2, S_PAUSE, 4'h2, 0, 0);
    rows(4, 1, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN,   4'h2, 1, 0);
    rows(4, 1, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN,   4'h2, 1, 0);
    // Pause with count 1 held.
    rows(4, 0, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(1, 0, 2'd2, S_RUN,   4'h2, 1, 0);
    rows(1, 0, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(10, 1, 2'd2, S_PAUSE, 4'h2, 0, 0);
    // Resume, same sw: step after remaining 3 counts.
    rows(6, 0, 2'd2, S_PAUSE, 4'h2, 0, 0);
    rows(3, 1, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN,   4'h2, 1, 0);
    rows(4, 1, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(1, 1, 2'd2, S_RUN,   4'h2, 1, 0);
    // Pause again (count 1 held); sw moves to 3 while paused, mode unchanged.
    rows(4, 0, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(1, 0, 2'd2, S_RUN,   4'h2, 1, 0);
    rows(1, 0, 2'd2, S_RUN,   4'h2, 0, 0);
    rows(8, 1, 2'd3, S_PAUSE, 4'h2, 0, 0);
    // Press with new sw: LOAD, mode 3, prescaler restarts from 0.
    rows(6, 0, 2'd3, S_PAUSE, 4'h2, 0, 0);
    rows(1, 1, 2'd3, S_LOAD,  4'h3, 0, 1);
    rows(4, 1, 2'd3, S_RUN,   4'h3, 0, 0);
    rows(1, 1, 2'd3, S_RUN,   4'h3, 1, 0);
    rows(4, 1, 2'd3, S_RUN,   4'h3, 0, 0);
    rows(1, 1, 2'd3, S_RUN,   4'h3, 1, 0);

    // Reset values before any edge.
    #1;
    check("reset_state", {state, mode, step, load}, 8'h00);
    repeat (3) @(posedge clock);
    #4 reset = 1'b1;

    foreach (vec[i]) begin
      key_n = vec[i].key_n;
      sw    = vec[i].sw;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d {state,mode,step,load}", i),
            {state, mode, step, load},
            {vec[i].st, vec[i].md, vec[i].stp, vec[i].ld});
    end

    // Last vector left a step pending; reset must kill it without an edge.
    #2 reset = 1'b0;
    #1;
    check("async_rst_step",  32'(step),  32'h0);
    check("async_rst_load",  32'(load),  32'h0);
    check("async_rst_state", 32'(state), 32'h0);
    check("async_rst_mode",  32'(mode),  32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("held_rst_outputs", {state, mode, step, load}, 8'h00);
    #3 reset = 1'b1;

    // After release: stays IDLE until a fresh press.
    key_n = 1'b1;
    sw    = 2'd1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("post_rst_idle%0d", c), {state, mode, step, load}, 8'h00);
    end

    key_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock);
      #1;
      if (e < 7)
        check($sformatf("repress_e%0d", e), {state, mode, step, load}, {S_IDLE, 4'h0, 1'b0, 1'b0});
      else if (e == 7)
        check($sformatf("repress_e%0d", e), {state, mode, step, load}, {S_LOAD, 4'h1, 1'b0, 1'b1});
      else
        check($sformatf("repress_e%0d", e), {state, mode, step, load}, {S_RUN, 4'h1, 1'b0, 1'b0});
    end
    key_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

Run/pause/mode controller for the LED pattern datapath on the 10 MHz board clock. It debounces the mode pushbutton and latches the 2-bit mode switches on a button press. It generates the one-cycle `step` enable that advances the pattern state register, and a one-cycle `load` strobe that reseeds the pattern on a mode change. It replaces the free-running divided clock with a single-clock enable scheme: the pattern register and next-state logic run on `clock`, qualified by `step`/`load`.

## Interface
Parameters:
- TICK_DIV, 5_000_000, clock cycles per `step` pulse while running (10 MHz → 2 Hz); must be ≥ 2
- DEBOUNCE, 200_000, consecutive stable cycles required to accept a button level change (20 ms); must be ≥ 2

Ports:
- clock  in  1  board clock (ADC_CLK_10 domain); all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- key_n  in  1  raw pushbutton (KEY[1]), active-low, asynchronous to `clock`
- sw     in  2  requested mode (SW[1:0]), quasi-static
- mode   out 4  current mode, {2'b00, latched sw}; feeds next-state logic and 7-seg
- step   out 1  one-cycle pulse: advance pattern register
- load   out 1  one-cycle pulse: reload pattern seed for `mode`
- state  out 2  FSM code: 00 IDLE, 01 LOAD, 10 RUN, 11 PAUSE

## Operation
- Input conditioning: 2-flop synchronizer on key_n (reset value 1). Debounced level `db` has reset value 1 (released). Counter `dc`:
  - `dc` clears whenever the synchronized level equals `db`; otherwise it increments.
  - When `dc == DEBOUNCE-1` and the level still differs, `db` takes the synchronized level and `dc` clears.
  - `press` is a registered one-cycle pulse on the `db` 1→0 transition. Release generates no event.
  - A glitch shorter than DEBOUNCE cycles produces no event.
- FSM (all transitions on `press` unless noted):
  - IDLE: on press, `mode` ← {00, sw}, go to LOAD.
  - LOAD: lasts exactly one cycle; `load`=1; prescaler cleared; unconditionally go to RUN.
  - RUN: prescaler counts 0..TICK_DIV-1. At TICK_DIV-1, `step`=1 for that cycle and the prescaler wraps to 0. On press, go to PAUSE; the prescaler holds.
  - PAUSE: no steps; prescaler holds its value. On press:
    - If sw ≠ mode[1:0]: `mode` ← {00, sw}, go to LOAD.
    - Otherwise go to RUN, resuming the held count with no load.
- sw changes outside a press are ignored; `mode` changes only on IDLE→LOAD or PAUSE→LOAD.
- `step` and `load` are never high in the same cycle. `step` is high only in RUN.
- `step` and `load` are combinational decodes of registered state and prescaler (glitch-free, no input paths).

## Timing
- Reset (asynchronous assert) values: mode=0, step=0, load=0, state=00, prescaler=0, dc=0, sync flops=1, db=1, press=0.
- Reset deassertion takes effect at the next clock edge. Reset asserted mid-RUN or mid-LOAD drops `step`/`load` immediately, with no completion.
- Press latency: key_n low before edge 1 and held → `state` changes after edge DEBOUNCE+3.
- LOAD→RUN: `load` is high for exactly 1 cycle. The first `step` occurs TICK_DIV cycles after RUN entry, then every TICK_DIV cycles.
- A press in the same cycle that the prescaler reaches TICK_DIV-1 in RUN: that `step` is still emitted, then PAUSE is entered. The prescaler holds at the wrapped value 0.
- A press cannot arrive in LOAD: presses are ≥ DEBOUNCE cycles apart.

## Test plan
All directed tests use TICK_DIV=5, DEBOUNCE=4.
- Reset, then idle for 20 cycles → state=00, mode=0, step=0, load=0 throughout.
- sw=2, key_n low for 10 cycles → state=01 after edge 7 with load=1 for one cycle, mode=4'h2, then state=10. Steps occur 5, 10 and 15 cycles after RUN entry.
- Glitch key_n low for 3 cycles in RUN → no state change, step cadence unaffected.
- In RUN, press → PAUSE with no steps for 30 cycles. Press again with sw unchanged → RUN, no load, next step at the remaining held count.
- In PAUSE, set sw=3 and press → LOAD pulse, mode=4'h3, prescaler restarts, first step 5 cycles after RUN entry.
- Assert reset low in the middle of a RUN cycle with step pending → outputs return to reset values asynchronously. After release, the FSM is in IDLE and requires a new press.
